game_tick_scheduler: RTL and testbench

- Central timing controller for the game.
- Runs a base prescaler that divides the system clock into a frame tick, nominally 60 Hz.
- Fans the frame tick out to three channels, each with its own programmable frame-count period: ch0 bird physics, ch1 pipe scroll, ch2 score/blink.
- The top-level FSM sequences it (start/pause), and periods are written through a valid/ready config port.

---
 rtl/game_tick_scheduler.sv | 134 +++++++++++++
 tb/tb_game_tick_scheduler.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler: central game timing controller.
// A base prescaler divides the system clock into a frame tick. The frame
// tick is fanned out to three channels, each with its own programmable
// period in frames. A small IDLE/RUN/PAUSED FSM sequences the counters,
// and channel periods are written through a valid/ready config port that
// only accepts writes while timing is not running.
module game_tick_scheduler #(
  parameter int BASE_DIV = 833334,
  parameter int PW       = 8,
  parameter int DEF0     = 1,
  parameter int DEF1     = 4,
  parameter int DEF2     = 30
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          pause,
  input  logic          cfg_valid,
  input  logic [1:0]    cfg_sel,
  input  logic [PW-1:0] cfg_period,
  output logic          cfg_ready,
  output logic [1:0]    state,
  output logic          frame_tick,
  output logic [2:0]    ch_tick,
  output logic [15:0]   frame_count
);

  localparam int PSW = $clog2(BASE_DIV);
  localparam logic [PSW-1:0] PRE_LOAD = PSW'(BASE_DIV - 1);
  // Reset periods packed so each channel slice can pick its own default.
  localparam logic [3*PW-1:0] DEF_PACK = {PW'(DEF2), PW'(DEF1), PW'(DEF0)};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [PSW-1:0] pre_q;
  logic [15:0]    fcount_q;
  logic [2:0]     cnt_zero;
  logic           tick_w;
  logic           run_adv;
  logic           cfg_fire;
  logic [PW-1:0]  cfg_period_sat;

  // A frame boundary is a pure decode of registered state.
  assign tick_w   = (state_q == RUN) && (pre_q == '0);
  // Counters only move in RUN when neither restart nor pause is requested.
  assign run_adv  = (state_q == RUN) && !start && !pause;
  assign cfg_fire = cfg_valid && cfg_ready;
  // A zero period would never reload sensibly, so it is stored as one.
  assign cfg_period_sat = (cfg_period == '0) ? PW'(1) : cfg_period;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: start beats pause from any state.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     state_d = pause ? PAUSED : RUN;
        PAUSED:  state_d = pause ? PAUSED : RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output decode from registered state and counters.
  always_comb begin
    state      = state_q;
    frame_tick = tick_w;
    ch_tick    = tick_w ? cnt_zero : 3'b000;
    cfg_ready  = (state_q != RUN) && !reset;
  end

  // Base prescaler and frame counter; both restart from phase zero on start.
  always_ff @(posedge clk) begin
    if (reset || start) begin
      pre_q    <= PRE_LOAD;
      fcount_q <= '0;
    end else if (run_adv) begin
      pre_q <= (pre_q == '0) ? PRE_LOAD : pre_q - 1'b1;
      if (tick_w) begin
        fcount_q <= fcount_q + 16'd1;
      end
    end
  end

  assign frame_count = fcount_q;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
      localparam logic [PW-1:0] DEF_I = DEF_PACK[gi*PW +: PW];
      logic [PW-1:0] period_q;
      logic [PW-1:0] cnt_q;

      // Channel period register, written only through the config port.
      always_ff @(posedge clk) begin
        if (reset) begin
          period_q <= DEF_I;
        end else if (cfg_fire && (cfg_sel == 2'(gi))) begin
          period_q <= cfg_period_sat;
        end
      end

      // Frame down-counter; start reloads from the period held before any
      // same-cycle write, so a new period takes effect at the first reload.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_q <= DEF_I - 1'b1;
        end else if (start) begin
          cnt_q <= period_q - 1'b1;
        end else if (run_adv && tick_w) begin
          cnt_q <= (cnt_q == '0) ? period_q - 1'b1 : cnt_q - 1'b1;
        end
      end

      assign cnt_zero[gi] = (cnt_q == '0);
    end
  endgenerate

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Testbench for game_tick_scheduler with BASE_DIV=4 and default periods 1/4/30.
// Inputs change on the falling edge; outputs are compared 1 time unit later.
module tb_game_tick_scheduler;

  logic        clk;
  logic        reset;
  logic        start;
  logic        pause;
  logic        cfg_valid;
  logic [1:0]  cfg_sel;
  logic [7:0]  cfg_period;
  logic        cfg_ready;
  logic [1:0]  state;
  logic        frame_tick;
  logic [2:0]  ch_tick;
  logic [15:0] frame_count;

  int n_checks = 0;
  int n_fail   = 0;

  game_tick_scheduler #(
    .BASE_DIV(4), .PW(8), .DEF0(1), .DEF1(4), .DEF2(30)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pause      (pause),
    .cfg_valid  (cfg_valid),
    .cfg_sel    (cfg_sel),
    .cfg_period (cfg_period),
    .cfg_ready  (cfg_ready),
    .state      (state),
    .frame_tick (frame_tick),
    .ch_tick    (ch_tick),
    .frame_count(frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          n;
    logic        rst;
    logic        st;
    logic        pa;
    logic        cv;
    logic [1:0]  sel;
    logic [7:0]  per;
    logic [1:0]  e_state;
    logic        e_ft;
    logic [2:0]  e_ch;
    logic        e_rdy;
    logic [15:0] e_fc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(int n, logic rst, logic st, logic pa, logic cv,
                              logic [1:0] sel, logic [7:0] per,
                              logic [1:0] est, logic eft, logic [2:0] ech,
                              logic erdy, logic [15:0] efc);
    vec_t v;
    v.n = n; v.rst = rst; v.st = st; v.pa = pa; v.cv = cv; v.sel = sel;
    v.per = per; v.e_state = est; v.e_ft = eft; v.e_ch = ech;
    v.e_rdy = erdy; v.e_fc = efc;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] est, input logic eft,
                           input logic [2:0] ech, input logic erdy, input logic [15:0] efc);
    $display("[%0t] %s: state=%0d ft=%0b ch=%b rdy=%0b fc=%0d", $time, tag,
             state, frame_tick, ch_tick, cfg_ready, frame_count);
    chk({tag, " state"},       16'(state),      16'(est));
    chk({tag, " frame_tick"},  16'(frame_tick), 16'(eft));
    chk({tag, " ch_tick"},     16'(ch_tick),    16'(ech));
    chk({tag, " cfg_ready"},   16'(cfg_ready),  16'(erdy));
    chk({tag, " frame_count"}, frame_count,     efc);
  endtask

  task automatic drive(input logic rst, input logic st, input logic pa, input logic cv,
                       input logic [1:0] sel, input logic [7:0] per);
    @(negedge clk);
    reset = rst; start = st; pause = pa; cfg_valid = cv; cfg_sel = sel; cfg_period = per;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0;
    cfg_valid = 1'b0; cfg_sel = 2'd0; cfg_period = 8'd0;

    // n  rst st pa cv sel per  | state ft ch      rdy fc
    // Basic run with default periods 1/4/30.
    add(1, 1, 0, 0, 0, 0, 0,    0, 0, 3'b000, 0, 0);
    add(3, 0, 0, 0, 0, 0, 0,    0, 0, 3'b000, 1, 0);
    add(1, 0, 1, 0, 0, 0, 0,    0, 0, 3'b000, 1, 0);
    add(3, 0, 0, 0, 0, 0, 0,    1, 0, 3'b000, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,    1, 1, 3'b001, 0, 0);
    add(3, 0, 0, 0, 0, 0, 0,    1, 0, 3'b000, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0,    1, 1, 3'b001, 0, 1);
    add(3, 0, 0, 0, 0, 0, 0,    1, 0, 3'b000, 0, 2);
    add(1, 0, 0, 0, 0, 0, 0,    1, 1, 3'b001, 0, 2);
    add(3, 0, 0, 0, 0, 0, 0,    1, 0, 3'b000, 0, 3);
    add(1, 0, 0, 0, 0, 0, 0,    1, 1, 3'b011, 0, 3);
    add(3, 0, 0, 0, 0, 0, 0,    1, 0, 3'b000, 0, 4);
    add(1, 0, 0, 0, 0, 0, 0,    1, 1, 3'b001, 0, 4);
    add(3, 0, 0, 0, 0, 0, 0,    1, 0, 3'b000, 0, 5);
    add(1, 0, 0, 0, 0, 0, 0,    1, 1, 3'b001, 0, 5);
    add(3, 0, 0, 0, 0, 0, 0,    1, 0, 3'b000, 0, 6);
    add(1, 0, 0, 0, 0, 0, 0,    1, 1, 3'b001, 0, 6);
    add(2, 0, 0, 0, 0, 0, 0,    1, 0, 3'b000, 0, 7);
    // Reset mid-RUN with frame_count=7.
    add(1, 1, 0, 0, 0, 0, 0,    1, 0, 3'b000, 0, 7);
    add(2, 0, 0, 0, 0, 0, 0,    0, 0, 3'b000, 1, 0);
    // IDLE config writes: ch1=2, ch2=0 (stored as 1), then start.
    add(1, 0, 0, 0, 1, 1, 2,    0, 0, 3'b000, 1, 0);
    add(1, 0, 0, 0, 1, 2, 0,    0, 0, 3'b000, 1, 0);
    add(1, 0, 1, 0, 0, 0, 0,    0, 0, 3'b000, 1, 0);
    add(3, 0, 0, 0, 0, 0, 0,    1, 0, 3'b000, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0,    1, 1, 3'b101, 0, 0);
    add(3, 0, 0, 0, 0, 0, 0,    1, 0, 3'b000, 0, 1);
    add(1, 0, 0, 0, 0, 0, 0,    1, 1, 3'b111, 0, 1);
    add(3, 0, 0, 0, 0, 0, 0,    1, 0, 3'b000, 0, 2);
    add(1, 0, 0, 0, 0, 0, 0,    1, 1, 3'b101, 0, 2);
    add(3, 0, 0, 0, 0, 0, 0,    1, 0, 3'b000, 0, 3);
    add(1, 0, 0, 0, 0, 0, 0,    1, 1, 3'b111, 0, 3);
    add(3, 0, 0, 0, 0, 0, 0,    1, 0, 3'b000, 0, 4);
    add(1, 0, 0, 0, 0, 0, 0,    1, 1, 3'b101, 0, 4);
    add(3, 0, 0, 0, 0, 0, 0,    1, 0, 3'b000, 0, 5);
    add(1, 0, 0, 0, 0, 0, 0,    1, 1, 3'b111, 0, 5);

    // Initial reset cycle; state is unknown before the first edge.
    @(negedge clk);

    foreach (tbl[r]) begin
      for (int j = 0; j < tbl[r].n; j++) begin
        drive(tbl[r].rst, tbl[r].st, tbl[r].pa, tbl[r].cv, tbl[r].sel, tbl[r].per);
        check_all($sformatf("vec%0d.%0d", r, j), tbl[r].e_state, tbl[r].e_ft,
                  tbl[r].e_ch, tbl[r].e_rdy, tbl[r].e_fc);
      end
    end

    // Config request while running is refused; accepted once PAUSED.
    // Prescaler is 3 here, frame_count 6, periods 1/2/1.
    drive(0, 0, 0, 1, 0, 5); check_all("t3 run req",       1, 0, 3'b000, 0, 6);
    drive(0, 0, 1, 1, 0, 5); check_all("t3 pause edge",    1, 0, 3'b000, 0, 6);
    drive(0, 0, 1, 1, 0, 5); check_all("t3 paused accept", 2, 0, 3'b000, 1, 6);
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 1, 0, 0, 0); check_all("t4 frozen", 2, 0, 3'b000, 1, 6);
    end
    drive(0, 0, 0, 0, 0, 0); check_all("t4 unpause",    2, 0, 3'b000, 1, 6);
    drive(0, 0, 0, 0, 0, 0); check_all("t4 run pre2",   1, 0, 3'b000, 0, 6);
    drive(0, 0, 0, 0, 0, 0); check_all("t4 run pre1",   1, 0, 3'b000, 0, 6);
    drive(0, 0, 0, 0, 0, 0); check_all("t4 phase tick", 1, 1, 3'b101, 0, 6);
    // ch0 now reloads with period 5; ch1 period 2; ch2 period 1.
    for (int k = 1; k <= 5; k++) begin
      for (int j = 0; j < 3; j++) begin
        drive(0, 0, 0, 0, 0, 0); check_all("t3 gap", 1, 0, 3'b000, 0, 16'(6 + k));
      end
      drive(0, 0, 0, 0, 0, 0);
      check_all($sformatf("t3 frame%0d", k), 1, 1,
                {1'b1, (k % 2) == 1, k == 5}, 0, 16'(6 + k));
    end

    // Start and pause together in RUN: restart wins, then pause takes effect.
    drive(0, 1, 1, 0, 0, 0); check_all("t6 start+pause", 1, 0, 3'b000, 0, 12);
    drive(0, 0, 1, 0, 0, 0); check_all("t6 restarted",   1, 0, 3'b000, 0, 0);
    drive(0, 0, 1, 0, 0, 0); check_all("t6 paused",      2, 0, 3'b000, 1, 0);
    drive(0, 0, 0, 0, 0, 0); check_all("t6 unpause",     2, 0, 3'b000, 1, 0);
    for (int j = 0; j < 3; j++) begin
      drive(0, 0, 0, 0, 0, 0); check_all("t6 gap", 1, 0, 3'b000, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0); check_all("t6 first tick", 1, 1, 3'b100, 0, 0);

    // Reset restores default periods 1/4/30; sel=3 write is a no-op.
    drive(1, 0, 0, 0, 0, 0); check_all("t5 reset",    1, 0, 3'b000, 0, 1);
    drive(0, 0, 0, 0, 0, 0); check_all("t5 idle",     0, 0, 3'b000, 1, 0);
    drive(0, 0, 0, 0, 0, 0); check_all("t5 idle",     0, 0, 3'b000, 1, 0);
    drive(0, 0, 0, 1, 3, 9); check_all("t5 sel3 wr",  0, 0, 3'b000, 1, 0);
    drive(0, 1, 0, 0, 0, 0); check_all("t5 start",    0, 0, 3'b000, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      for (int j = 0; j < 3; j++) begin
        drive(0, 0, 0, 0, 0, 0); check_all("t5 gap", 1, 0, 3'b000, 0, 16'(k - 1));
      end
      drive(0, 0, 0, 0, 0, 0);
      check_all($sformatf("t5 frame%0d", k), 1, 1, {1'b0, k == 4, 1'b1}, 0, 16'(k - 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
